// File: rtl/ofm_sram_buffer.sv
// Purpose : OFM global-buffer storage: single-port SRAM model (DEPTH x LANES x LANE_W)
//           with a wrapper that shares the one port between separate read/write buses.
// Latency : read data valid exactly 1 cycle after read_en; data_out holds it until the next read.
// Backpr. : none; a write wins over a same-cycle read, which is silently dropped.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset (clears output path only)
//   addr_r / addr_w   read / write addresses, muxed onto the single SRAM port
//   read_en/write_en  access requests; write has priority
//   wr_mask           per-lane write enable, lane i = data bits [i*LANE_W +: LANE_W]
//   data_in           write data
//   data_out          read data, held stable between completed reads
module ofm_sram_buffer #(
  parameter int DEPTH_BIT = 8,
  parameter int LANES     = 12,
  parameter int LANE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DEPTH_BIT-1:0]      addr_r,
  input  logic [DEPTH_BIT-1:0]      addr_w,
  input  logic                      read_en,
  input  logic                      write_en,
  input  logic [LANES-1:0]          wr_mask,
  input  logic [LANES*LANE_W-1:0]   data_in,
  output logic [LANES*LANE_W-1:0]   data_out
);

  localparam int WIDTH = LANES * LANE_W;
  localparam int DEPTH = 1 << DEPTH_BIT;

  // Array is never reset: contents survive rst_n, as a real macro would.
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_mem_q;
  logic [WIDTH-1:0]     r_hold_q;
  logic                 r_rd_d;

  logic [DEPTH_BIT-1:0] w_port_addr;
  logic                 w_cs;
  logic                 w_wr;
  logic                 w_rd;

  // Single port: write address takes the port whenever a write is requested.
  assign w_port_addr = write_en ? addr_w : addr_r;
  assign w_cs        = write_en | read_en;
  assign w_wr        = w_cs & write_en;
  // A read colliding with a write is dropped, not deferred.
  assign w_rd        = w_cs & ~write_en;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          r_mem[w_port_addr][i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_q <= '0;
    end else if (w_rd) begin
      r_mem_q <= r_mem[w_port_addr];
    end
  end

  // Marks the cycle in which r_mem_q carries freshly read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d <= 1'b0;
    end else begin
      r_rd_d <= w_rd;
    end
  end

  // Capture the fresh word so it can be replayed while r_mem_q is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_q <= '0;
    end else if (r_rd_d) begin
      r_hold_q <= r_mem_q;
    end
  end

  assign data_out = r_rd_d ? r_mem_q : r_hold_q;

endmodule

// File: tb/tb_ofm_sram_buffer.sv
// Purpose : self-checking bench for ofm_sram_buffer (directed scenarios + randomized traffic).
// Latency : compares data_out 1ns after every rising edge against a behavioural model.
// Backpr. : n/a.
module tb_ofm_sram_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr_r;
  logic [7:0]  addr_w;
  logic        read_en;
  logic        write_en;
  logic [11:0] wr_mask;
  logic [95:0] data_in;
  logic [95:0] data_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model: word array plus "value of the last completed read".
  logic [95:0] mdl [256];
  logic [95:0] exp_out;

  localparam logic [95:0] VAL_A = 96'h0123_4567_89AB_CDEF_0123_45AB;
  localparam logic [95:0] VAL_B = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
  localparam logic [95:0] VAL_C = 96'h5A5A_A5A5_0F0F_F0F0_1357_9BDF;

  ofm_sram_buffer #(.DEPTH_BIT(8), .LANES(12), .LANE_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_r   (addr_r),
    .addr_w   (addr_w),
    .read_en  (read_en),
    .write_en (write_en),
    .wr_mask  (wr_mask),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One clock cycle of stimulus; model updated at the edge, returns 1ns after it.
  task automatic cyc(input logic re, input logic [7:0] ar, input logic we,
                     input logic [7:0] aw, input logic [11:0] m, input logic [95:0] d);
    read_en  = re;
    addr_r   = ar;
    write_en = we;
    addr_w   = aw;
    wr_mask  = m;
    data_in  = d;
    @(posedge clk);
    if (re && !we) exp_out = mdl[ar];
    if (we) begin
      for (int i = 0; i < 12; i++)
        if (m[i]) mdl[aw][i*8 +: 8] = d[i*8 +: 8];
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 12'h000, 96'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read_en = 1'b0; write_en = 1'b0; addr_r = '0; addr_w = '0; wr_mask = '0; data_in = '0;
    exp_out = '0;
    #12;
    checks++;
    if (data_out !== 96'd0) begin
      errors++; $display("FAIL reset_out: actual=%h required=%h", data_out, 96'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (data_out !== 96'd0) begin
        errors++; $display("FAIL reset_idle%0d: actual=%h required=%h", k, data_out, 96'd0);
      end
    end
  endtask

  task automatic test_write_read();
    cyc(1'b0, 8'd0, 1'b1, 8'd5, 12'hFFF, VAL_A);
    cyc(1'b1, 8'd5, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL wr_rd_latency: actual=%h required=%h", data_out, VAL_A);
    end
    for (int k = 0; k < 3; k++) idle();
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL wr_rd_hold: actual=%h required=%h", data_out, VAL_A);
    end
  endtask

  task automatic test_byte_mask();
    cyc(1'b0, 8'd0, 1'b1, 8'd7, 12'hFFF, {96{1'b1}});
    cyc(1'b0, 8'd0, 1'b1, 8'd7, 12'h001, 96'd0);
    // A write must not disturb the held output.
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL mask_write_hold: actual=%h required=%h", data_out, VAL_A);
    end
    cyc(1'b1, 8'd7, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00) begin
      errors++; $display("FAIL byte_mask: actual=%h required=%h", data_out,
                         96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00);
    end
    // Mask of zero: no lane changes.
    cyc(1'b0, 8'd0, 1'b1, 8'd7, 12'h000, 96'd0);
    cyc(1'b1, 8'd7, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00) begin
      errors++; $display("FAIL zero_mask: actual=%h required=%h", data_out,
                         96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00);
    end
  endtask

  task automatic test_collision();
    cyc(1'b1, 8'd5, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL coll_pre: actual=%h required=%h", data_out, VAL_A);
    end
    cyc(1'b1, 8'd5, 1'b1, 8'd9, 12'hFFF, VAL_B);
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL coll_hold: actual=%h required=%h", data_out, VAL_A);
    end
    idle();
    checks++;
    if (data_out !== VAL_A) begin
      errors++; $display("FAIL coll_hold2: actual=%h required=%h", data_out, VAL_A);
    end
    cyc(1'b1, 8'd9, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== VAL_B) begin
      errors++; $display("FAIL coll_write: actual=%h required=%h", data_out, VAL_B);
    end
  endtask

  task automatic test_streaming();
    for (int a = 0; a < 4; a++) cyc(1'b0, 8'd0, 1'b1, 8'(a), 12'hFFF, 96'(10 + a));
    for (int a = 0; a < 4; a++) begin
      cyc(1'b1, 8'(a), 1'b0, 8'd0, 12'h000, 96'd0);
      checks++;
      if (data_out !== 96'(10 + a)) begin
        errors++; $display("FAIL stream%0d: actual=%h required=%h", a, data_out, 96'(10 + a));
      end
    end
    idle(); idle();
    checks++;
    if (data_out !== 96'd13) begin
      errors++; $display("FAIL stream_hold: actual=%h required=%h", data_out, 96'd13);
    end
  endtask

  // Read-after-write in the very next cycle to the same address.
  task automatic test_back_to_back();
    cyc(1'b0, 8'd0, 1'b1, 8'd20, 12'hFFF, VAL_B);
    cyc(1'b1, 8'd20, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== VAL_B) begin
      errors++; $display("FAIL raw_next: actual=%h required=%h", data_out, VAL_B);
    end
  endtask

  task automatic test_reset_persist();
    cyc(1'b0, 8'd0, 1'b1, 8'd2, 12'hFFF, VAL_C);
    cyc(1'b1, 8'd2, 1'b0, 8'd0, 12'h000, 96'd0);
    #3 rst_n = 1'b0;
    exp_out = '0;
    #1;
    checks++;
    if (data_out !== 96'd0) begin
      errors++; $display("FAIL rst_async: actual=%h required=%h", data_out, 96'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    checks++;
    if (data_out !== 96'd0) begin
      errors++; $display("FAIL rst_after: actual=%h required=%h", data_out, 96'd0);
    end
    cyc(1'b1, 8'd2, 1'b0, 8'd0, 12'h000, 96'd0);
    checks++;
    if (data_out !== VAL_C) begin
      errors++; $display("FAIL rst_persist: actual=%h required=%h", data_out, VAL_C);
    end
  endtask

  task automatic test_reset_cancel();
    // Reset arrives while a read request is pending at the edge.
    read_en = 1'b1; addr_r = 8'd5; write_en = 1'b0;
    #3 rst_n = 1'b0;
    exp_out = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; read_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (data_out !== 96'd0) begin
        errors++; $display("FAIL rst_cancel%0d: actual=%h required=%h", k, data_out, 96'd0);
      end
    end
    // Reset in the cycle right after a read was accepted.
    cyc(1'b1, 8'd9, 1'b0, 8'd0, 12'h000, 96'd0);
    read_en = 1'b0;
    #2 rst_n = 1'b0;
    exp_out = '0;
    #1;
    checks++;
    if (data_out !== 96'd0) begin
      errors++; $display("FAIL rst_cancel_late: actual=%h required=%h", data_out, 96'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(); idle();
    checks++;
    if (data_out !== 96'd0) begin
      errors++; $display("FAIL rst_cancel_hold: actual=%h required=%h", data_out, 96'd0);
    end
  endtask

  task automatic test_random();
    logic [95:0] d;
    int op;
    for (int a = 0; a < 256; a++) begin
      d = {$urandom, $urandom, $urandom};
      cyc(1'b0, 8'd0, 1'b1, 8'(a), 12'hFFF, d);
    end
    for (int n = 0; n < 800; n++) begin
      op = $urandom_range(0, 3);
      d  = {$urandom, $urandom, $urandom};
      case (op)
        0: idle();
        1: cyc(1'b1, 8'($urandom), 1'b0, 8'($urandom), 12'($urandom), d);
        2: cyc(1'b0, 8'($urandom), 1'b1, 8'($urandom), 12'($urandom), d);
        default: cyc(1'b1, 8'($urandom), 1'b1, 8'($urandom), 12'($urandom), d);
      endcase
      checks++;
      if (data_out !== exp_out) begin
        errors++; $display("FAIL random%0d op%0d: actual=%h required=%h", n, op, data_out, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_collision();
    test_streaming();
    test_back_to_back();
    test_reset_persist();
    test_reset_cancel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_sram_buffer.md
Name: ofm_sram_buffer

Overview:
- Global-buffer output-feature-map storage block: a single-port synchronous SRAM (behavioural model of the 256x8x12 macro) with a small port-sharing wrapper.
- The wrapper muxes separate read and write address buses onto the single port.
- A 1-stage read-enable delay stage marks when read data is valid.
- data_out holds the last read word stable until the next read completes.
- Sits between the PE array write-back path and the OFM read-out/DMA path.

Parameters:
- DEPTH_BIT, 8, address width; DEPTH = 2**DEPTH_BIT words.
- LANES, 12, number of byte-write lanes.
- LANE_W, 8, bits per lane; WIDTH = LANES*LANE_W (default 96).

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
- addr_r  in  DEPTH_BIT  read address.
- addr_w  in  DEPTH_BIT  write address.
- read_en  in  1  read request (active high).
- write_en  in  1  write request (active high).
- wr_mask  in  LANES  per-lane write enable; lane i covers data bits [i*8+7:i*8]; 1 = write.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  read data, held between reads.

Behaviour:
- Port arbitration: the port address is addr_w when write_en=1, else addr_r.
  - The chip-select is active when write_en | read_en.
  - When both are idle the array is untouched.
- Write: at a rising clk edge with write_en=1, every lane i with wr_mask[i]=1 is stored from data_in into mem[addr_w].
  - Lanes with wr_mask[i]=0 keep their old value.
  - wr_mask=0 with write_en=1 is a no-op write, but the read is still blocked.
- Read: at a rising clk edge with read_en=1 and write_en=0, mem_q <= mem[addr_r].
  - Read-to-data latency is exactly 1 cycle.
- Collision (read_en=1 and write_en=1 together): the write is performed and the read is dropped.
  - rd_d is 0 in the next cycle, so data_out keeps its held value.
- Read-valid delay stage: rd_d <= read_en & ~write_en, a 1-stage register with async reset to 0.
- Output: data_out = rd_d ? mem_q : hold_q.
  - hold_q <= mem_q on every clk edge where rd_d=1.
  - Result: data_out shows new data in the cycle after a read and stays unchanged through idle or write cycles.
- Back-to-back reads stream one word per cycle; each is valid in the cycle after its request.
- Read-after-write to the same address in the following cycle returns the new data. No bypass is needed, because the port is used serially.
- Reset (async, rst_n=0):
  - rd_d=0, mem_q=0, hold_q=0, so data_out=0 immediately.
  - Memory array contents are NOT cleared.
  - Reset mid-read cancels the pending valid; data_out=0 until the next completed read.
- Unwritten locations read as undefined (X in simulation); benches must write before reading.
- Addresses span the full 2**DEPTH_BIT range with no out-of-range case.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> data_out=0 at once; after release with no reads, data_out stays 0.
- Write/read:
  - Write 0x0123...AB (96-bit) to addr 5 with wr_mask=0xFFF.
  - Next cycle, read addr 5 -> data_out = written value in the cycle after read_en.
  - data_out still equals it 3 idle cycles later.
- Byte mask:
  - Write all-ones to addr 7 (mask 0xFFF), then write all-zeros with mask 0x001.
  - Read addr 7 -> 0xFFFF...FF00.
- Collision:
  - Read addr 5 first so data_out=A.
  - Then drive read_en=1 and write_en=1 with addr_w=9, data B -> data_out stays A.
  - A subsequent read of addr 9 -> B.
- Streaming: write addr 0..3 with values 10..13, then read 0..3 on consecutive cycles -> data_out = 10, 11, 12, 13 on the four following cycles, then holds 13.
- Reset mid-operation:
  - Data persists: write addr 2 = C, pulse rst_n low -> data_out=0; reading addr 2 after reset -> C.
  - Pending read cancelled: pulse rst_n low in the cycle after a read request -> that read never appears on data_out, which stays 0.
